// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// flags, overflow/underflow pulses and an optional first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_THRESH);

  if ((DEPTH < 2) || (AF_THRESH > DEPTH) || (AE_THRESH >= DEPTH)) begin : g_bad_cfg
    $error("sync_fifo_param: invalid DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             almost_full_reg;
  logic             almost_empty_reg;
  logic             overflow_reg;
  logic             underflow_reg;

  logic             wr_accept;
  logic             rd_accept;

  // Status is taken from the registered flags, so a full FIFO never
  // writes through and an empty FIFO never reads through.
  assign wr_accept = wr_en && !full_reg;
  assign rd_accept = rd_en && !empty_reg;

  assign wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
  assign rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;

  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_next;
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_next;
      end
      count_reg        <= count_next;
      full_reg         <= (count_next == DEPTH_CNT);
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= AF_CNT);
      almost_empty_reg <= (count_next <= AE_CNT);
      overflow_reg     <= wr_en && full_reg;
      underflow_reg    <= rd_en && empty_reg;
    end
  end

  // Storage carries no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign dout = empty_reg ? '0 : mem[rd_ptr_reg];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_reg <= '0;
      end else if (rd_accept) begin
        dout_reg <= mem[rd_ptr_reg];
      end
    end

    assign dout = dout_reg;
  end

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule
